// File: rtl/peripheral_ahb2wb_pkg.sv
// peripheral_ahb2wb_pkg: shared AHB/Wishbone encodings and bridge state type.
// Imported by the AHB-to-Wishbone bridge and its byte-lane decoder.
package peripheral_ahb2wb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/peripheral_ahb2wb_sel.sv
// peripheral_ahb2wb_sel: byte-lane decode and size/alignment legality
// for a 32-bit AHB data bus.
module peripheral_ahb2wb_sel
  import peripheral_ahb2wb_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_sel,
  output logic       o_illegal
);

  always_comb begin
    o_sel     = 4'b0000;
    o_illegal = 1'b0;
    unique case (1'b1)
      (i_size == HSIZE_BYTE): begin
        o_sel = 4'b0001 << i_addr;
      end
      (i_size == HSIZE_HWORD): begin
        o_sel     = i_addr[1] ? 4'b1100 : 4'b0011;
        o_illegal = i_addr[0];
      end
      (i_size == HSIZE_WORD): begin
        o_sel     = 4'b1111;
        o_illegal = |i_addr;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/peripheral_bridge_ahb2wb.sv
// peripheral_bridge_ahb2wb: AHB3-Lite slave to Wishbone B3 classic master.
// One AHB data phase maps to one Wishbone cycle; faults become AHB ERROR.
module peripheral_bridge_ahb2wb
  import peripheral_ahb2wb_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [AW-1:0]         wb_adr_o,
  output logic [DW-1:0]         wb_dat_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic [1:0]            wb_bte_o,
  output logic [2:0]            wb_cti_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic [DW-1:0]         wb_dat_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_cyc;
  logic                  r_we;
  logic [AW-1:0]         r_adr;
  logic [3:0]            r_sel;
  logic                  r_hready;
  logic                  r_hresp;
  logic [HDATA_SIZE-1:0] r_hrdata;

  logic [3:0] w_sel;
  logic       w_illegal;
  logic       w_accept;
  logic       w_timeout;
  logic       w_unused;

  peripheral_ahb2wb_sel u_sel (
    .i_size    (HSIZE),
    .i_addr    (HADDR[1:0]),
    .o_sel     (w_sel),
    .o_illegal (w_illegal)
  );

  assign w_accept  = HSEL & HREADY & HTRANS[1];
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_sel    <= '0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_hrdata <= '0;
    end else begin
      unique case (r_state)
        // ERR2 is the completion cycle, so it accepts like IDLE
        ST_IDLE, ST_ERR2: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
          if (w_accept && w_illegal) begin
            r_state  <= ST_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
          end else if (w_accept) begin
            r_state  <= ST_WB_REQ;
            r_hready <= 1'b0;
            r_cyc    <= 1'b1;
            r_cnt    <= '0;
            r_adr    <= HADDR[AW+1:2];
            r_we     <= HWRITE;
            r_sel    <= w_sel;
          end
        end
        ST_WB_REQ: begin
          if (wb_err_i || w_timeout) begin
            r_state  <= ST_ERR1;
            r_cyc    <= 1'b0;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
          end else if (wb_ack_i) begin
            r_state  <= ST_IDLE;
            r_cyc    <= 1'b0;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
            if (!r_we) r_hrdata <= wb_dat_i;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign HREADYOUT = r_hready;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;

  // HWDATA is held by the master while HREADYOUT is low
  assign wb_dat_o = HWDATA;
  assign wb_adr_o = r_adr;
  assign wb_sel_o = r_sel;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_bte_o = WB_BTE_LINEAR;
  assign wb_cti_o = WB_CTI_CLASSIC;

  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0],
                      HADDR[HADDR_SIZE-1:AW+2]};

endmodule

// File: tb/tb_peripheral_bridge_ahb2wb.sv
// tb_peripheral_bridge_ahb2wb: directed plus random AHB traffic into the
// bridge, with a Wishbone RAM slave and a byte-level memory model.
module tb_peripheral_bridge_ahb2wb;
  import peripheral_ahb2wb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel, hwrite, hmastlock, hready, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [1:0]  wb_bte;
  logic [2:0]  wb_cti;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  peripheral_bridge_ahb2wb #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .AW(8), .DW(32), .TIMEOUT(TO)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr),
    .HWDATA(hwdata), .HRDATA(hrdata), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(hreadyout),
    .HRESP(hresp), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_bte_o(wb_bte),
    .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_dat_i)
  );

  // Wishbone slave: 0 = RAM with one-cycle ack, 1 = never acks, 2 = err+ack
  int          mode = 0;
  bit   [31:0] smem [256];
  logic [7:0]  log_adr [256];
  logic [3:0]  log_sel [256];
  logic        log_we  [256];
  logic [31:0] log_dat [256];
  int          nbeats = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
        if (mode == 0) begin
          wb_ack   <= 1'b1;
          wb_dat_i <= smem[wb_adr];
          if (wb_we)
            for (int b = 0; b < 4; b++)
              if (wb_sel[b]) smem[wb_adr][8*b +: 8] <= wb_dat_o[8*b +: 8];
          log_adr[nbeats[7:0]] <= wb_adr;
          log_sel[nbeats[7:0]] <= wb_sel;
          log_we[nbeats[7:0]]  <= wb_we;
          log_dat[nbeats[7:0]] <= wb_dat_o;
          nbeats <= nbeats + 1;
        end else if (mode == 2) begin
          wb_ack   <= 1'b1;
          wb_err   <= 1'b1;
          wb_dat_i <= $urandom;
        end
      end
    end
  end

  int   cyc_starts = 0;
  int   cyc_hi = 0;
  logic cyc_q = 1'b0;

  always @(negedge clk) begin
    cyc_q <= wb_cyc;
    if (wb_cyc) cyc_hi <= cyc_hi + 1;
    if (wb_cyc && !cyc_q) cyc_starts <= cyc_starts + 1;
  end

  // Reference: byte-addressed memory and last read data seen on HRDATA
  bit   [7:0]  model [1024];
  logic [31:0] exp_rd = 32'h0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] model_word(input int a);
    int w;
    w = a & ~3;
    return {model[w+3], model[w+2], model[w+1], model[w]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int waits, output logic resp,
                      output logic fresp);
    @(negedge clk);
    hsel   = 1'b1;
    haddr  = 32'(a);
    hwrite = w;
    hsize  = sz;
    htrans = HTRANS_NONSEQ;
    hburst = 3'b000;
    @(negedge clk);
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = wd;
    waits  = 0;
    fresp  = hresp;
    while (!hreadyout && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    rd   = hrdata;
    resp = hresp;
  endtask

  task automatic run(input int a, input logic w, input logic [2:0] sz,
                     input logic [31:0] wd, input string tag);
    int          n, b0, c0, waits;
    logic [31:0] rd;
    logic        resp, fresp, legal;
    logic [3:0]  esel;
    n     = 1 << sz;
    legal = (sz <= 3'd2) && (a % n == 0);
    b0    = nbeats;
    c0    = cyc_starts;
    xfer(a, w, sz, wd, rd, waits, resp, fresp);
    chk({tag, "_resp"}, 32'(resp), legal ? 32'd0 : 32'd1);
    chk({tag, "_waits"}, waits, legal ? 32'd2 : 32'd1);
    chk({tag, "_cycs"}, cyc_starts - c0, legal ? 32'd1 : 32'd0);
    if (!legal) chk({tag, "_err1resp"}, 32'(fresp), 32'd1);
    if (legal) begin
      esel = 4'(((1 << n) - 1) << (a % 4));
      chk({tag, "_adr"}, 32'(log_adr[b0[7:0]]), 32'(a >> 2));
      chk({tag, "_sel"}, 32'(log_sel[b0[7:0]]), 32'(esel));
      chk({tag, "_we"}, 32'(log_we[b0[7:0]]), 32'(w));
      if (w) begin
        chk({tag, "_wdat"}, log_dat[b0[7:0]], wd);
        for (int k = 0; k < n; k++)
          model[a+k] = wd[8*((a+k)%4) +: 8];
      end else begin
        exp_rd = model_word(a);
      end
    end
    chk({tag, "_hrdata"}, rd, exp_rd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          waits, b0, c0;
    logic [31:0] rd;
    logic        resp, fresp;

    hsel = 0; haddr = 0; hwdata = 0; hwrite = 0; hsize = HSIZE_WORD;
    hburst = 0; hprot = 0; htrans = HTRANS_IDLE; hmastlock = 0;

    repeat (3) @(negedge clk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_cyc_stb", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
    chk("rst_adr_sel", 32'({wb_adr, wb_sel}), 32'd0);
    chk("rst_cti_bte", 32'({wb_cti, wb_bte}), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of an outstanding Wishbone cycle
    mode = 1;
    @(negedge clk);
    hsel = 1; haddr = 32'h10; hwrite = 0; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    hsel = 0; htrans = HTRANS_IDLE;
    @(negedge clk);
    chk("midrst_cyc_before", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_cyc_async", 32'({wb_cyc, wb_stb}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;
    @(negedge clk);
    chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
    chk("midrst_hresp", 32'(hresp), 32'd0);

    run(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, "w_word");
    run(32'h10, 1'b0, HSIZE_WORD, 32'h0, "r_word");
    chk("r_word_const", hrdata, 32'hDEADBEEF);
    run(32'h13, 1'b1, HSIZE_BYTE, 32'hAB000000, "w_byte");
    run(32'h10, 1'b0, HSIZE_WORD, 32'h0, "r_after_byte");
    chk("r_after_byte_const", hrdata, 32'hABADBEEF);
    run(32'h01, 1'b0, HSIZE_HWORD, 32'h0, "hw_misalign");

    // Slave never answers
    mode = 1;
    c0 = cyc_hi;
    xfer(32'h40, 1'b0, HSIZE_WORD, 32'h0, rd, waits, resp, fresp);
    chk("to_waits", waits, TO + 1);
    chk("to_resp", 32'(resp), 32'd1);
    chk("to_cyc_len", cyc_hi - c0, TO);
    chk("to_hrdata", rd, exp_rd);

    // Slave raises err and ack together
    mode = 2;
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, rd, waits, resp, fresp);
    chk("errack_waits", waits, 32'd3);
    chk("errack_resp", 32'(resp), 32'd1);
    chk("errack_hrdata", rd, exp_rd);
    mode = 0;

    for (int i = 0; i < 4; i++)
      run(32'h20 + 4 * i, 1'b1, HSIZE_WORD, $urandom, "burst_fill");

    // Pipelined INCR4 read burst: next address during each data phase
    b0 = nbeats;
    c0 = cyc_starts;
    @(negedge clk);
    hsel = 1; haddr = 32'h20; hwrite = 0; hsize = HSIZE_WORD;
    htrans = HTRANS_NONSEQ; hburst = 3'b011;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        haddr  = 32'h20 + 32'(4 * (i + 1));
        htrans = HTRANS_SEQ;
      end else begin
        hsel   = 0;
        htrans = HTRANS_IDLE;
      end
      waits = 0;
      while (!hreadyout && waits < 100) begin
        waits++;
        @(negedge clk);
      end
      exp_rd = model_word(32'h20 + 4 * i);
      chk("burst_waits", waits, 32'd2);
      chk("burst_resp", 32'(hresp), 32'd0);
      chk("burst_hrdata", hrdata, exp_rd);
      @(negedge clk);
    end
    chk("burst_cycs", cyc_starts - c0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_adr", 32'(log_adr[8'(b0 + i)]), 32'(8 + i));
      chk("burst_we", 32'(log_we[8'(b0 + i)]), 32'd0);
    end

    for (int i = 0; i < 40; i++)
      run(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 3)), $urandom, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/peripheral_bridge_ahb2wb.md
Name: peripheral_bridge_ahb2wb

Overview:
AHB3-Lite slave to Wishbone B3 classic master bridge. It is the upstream stage that drives peripheral_spram_wb, so the AHB interconnect can reach the single-port RAM. Each AHB data phase becomes one Wishbone classic cycle. Slave errors and missing acks are converted to the AHB two-cycle ERROR response.

Parameters:
HADDR_SIZE, 32, AHB address width
HDATA_SIZE, 32, AHB data width; must equal DW
AW, 8, Wishbone word-address width (matches SPRAM $clog2(DEPTH))
DW, 32, Wishbone data width
TIMEOUT, 255, max wait cycles for wb_ack_i/wb_err_i; 0 disables the timeout

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  HDATA_SIZE  write data (data phase)
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  burst type (ignored; each beat handled individually)
HPROT  in  4  protection (ignored)
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HMASTLOCK  in  1  lock (ignored)
HREADY  in  1  bus ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
wb_adr_o  out  AW  word address = HADDR[AW+1:2]
wb_dat_o  out  DW  write data
wb_sel_o  out  4  byte lanes
wb_we_o  out  1  write enable
wb_bte_o  out  2  burst type extension, constant 2'b00
wb_cti_o  out  3  cycle type identifier, constant 3'b000 (classic)
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
wb_dat_i  in  DW  read data

Behaviour:
- Reset (async, HRESETn=0) sets:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o and wb_sel_o all =0.
  - Timeout counter =0, state=IDLE.
  - An in-flight Wishbone cycle is dropped immediately; no response is issued.
- Transfer accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ).
  - On accept, register address, HWRITE and computed sel.
- IDLE and BUSY transfers get a zero-wait OKAY (HREADYOUT=1, HRESP=0) and start no Wishbone cycle.
- Byte-lane decode:
  - Byte: sel = 1<<HADDR[1:0].
  - Halfword: HADDR[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- Illegal transfers go to ERR1 with no Wishbone cycle:
  - HSIZE>2.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0]!=0.
- FSM states: IDLE, WB_REQ, ERR1, ERR2.
  - IDLE -> WB_REQ on a legal accept. From the next cycle, cyc=stb=1 and HREADYOUT=0.
  - In WB_REQ, wb_dat_o = HWDATA, combinational. This is legal because AHB holds HWDATA stable while HREADYOUT=0.
  - WB_REQ on wb_ack_i (and not wb_err_i): next cycle cyc=stb=0, HREADYOUT=1, HRESP=0; HRDATA<=wb_dat_i if a read (unchanged on a write); state -> IDLE.
  - WB_REQ on wb_err_i (err wins over a simultaneous ack), or timeout counter == TIMEOUT-1: next cycle cyc=stb=0; state -> ERR1.
  - ERR1: HRESP=1, HREADYOUT=0. -> ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. -> IDLE. A legal accept in ERR2 is processed as from IDLE.
- Timeout counter: cleared on entry to WB_REQ; increments each WB_REQ cycle without ack/err.
- Acks arriving while cyc=0 are ignored.
- Latency with a one-cycle-ack slave (SPRAM):
  - A = address phase.
  - A+1: stb asserted.
  - A+2: ack.
  - A+3: HREADYOUT=1 with data. Two AHB wait states per beat.
- Back-to-back: a new accept in the completion cycle (HREADYOUT=1) starts the next Wishbone cycle at the following cycle. No bubble beyond the FSM's.

Decomposition:
- Package peripheral_ahb2wb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE_BYTE/HWORD/WORD.
  - HRESP_OKAY/ERROR.
  - WB_CTI_CLASSIC, WB_BTE_LINEAR.
  - The state enum type.
- One sub-module, peripheral_ahb2wb_sel: combinational byte-lane decode plus alignment/size legality flag (HSIZE, HADDR[1:0] -> sel[3:0], illegal).

Test Plan:
- Reset mid-WB_REQ (HRESETn low 1 cycle) -> cyc/stb drop asynchronously; HREADYOUT=1, HRESP=0 after release.
- Word write 0xDEADBEEF to HADDR 0x10, then read 0x10:
  - Write: wb_adr_o=4, sel=4'hF, we=1.
  - Read: HRDATA=0xDEADBEEF with exactly 2 wait states each.
- Byte write 0xAB to HADDR 0x13, then word read of 0x10 -> wb_sel_o=4'b1000; HRDATA[31:24]=0xAB, other bytes unchanged.
- Halfword at HADDR 0x01 -> no wb_cyc_o; HRESP=1 for 2 cycles with HREADYOUT 0 then 1.
- Slave never acks (TIMEOUT=8) -> cyc drops after 8 cycles; two-cycle ERROR.
- Slave asserts wb_err_i and wb_ack_i together -> ERROR response; HRDATA unchanged.
- 4-beat INCR SEQ burst of reads at 0x20..0x2C -> four Wishbone classic cycles, adr 8..11, all OKAY.
